alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Execute-stage issue/retire controller wrapped around the 32-bit ripple ALU (alu).
//  Upstream: accepts decoded ALU ops over valid/ready and drives the ALU operand/control inputs from registers.
//  Downstream: samples result/zero/cout/overflow and queues them in a small output FIFO for writeback.
//  Also maintains an architectural flags register and a retired-op counter.
// PARAMETERS
//  WIDTH  32  datapath width; must equal ALU width
//  DEPTH  2   output FIFO entries; power of 2, >=2
//  CNT_W  16  width of retired-op counter
// PORTS
//  clk           in   1      clock; all state updates on posedge
//  rst           in   1      synchronous, active-high reset
//  in_valid      in   1      upstream op valid
//  in_ready      out  1      op accepted on clk edge when in_valid&&in_ready
//  in_op         in   4      ALU_control encoding (A_inv,B_inv,op[1:0])
//  in_bonus      in   3      bonus_control encoding
//  in_src1       in   WIDTH  operand 1
//  in_src2       in   WIDTH  operand 2
//  in_rd         in   5      destination register tag (passed through)
//  in_flag_we    in   1      op updates flags register on retire
//  alu_src1      out  WIDTH  registered drive to ALU src1
//  alu_src2      out  WIDTH  registered drive to ALU src2
//  alu_ctrl      out  4      registered drive to ALU_control
//  alu_bonus     out  3      registered drive to bonus_control
//  alu_result    in   WIDTH  ALU result (combinational from alu_* drives)
//  alu_zero      in   1      ALU zero
//  alu_cout      in   1      ALU carry out
//  alu_overflow  in   1      ALU signed overflow
//  out_valid     out  1      FIFO head valid (count!=0)
//  out_ready     in   1      downstream pops head when out_valid&&out_ready
//  out_result    out  WIDTH  head result
//  out_rd        out  5      head destination tag
//  out_flags     out  3      head {zero,cout,overflow}
//  flags         out  3      architectural {Z,C,V}
//  ovf_sticky    out  1      set on any retired overflow; cleared only by rst
//  retired_cnt   out  CNT_W  number of ops pushed into FIFO, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE; FIFO empty; alu_* drives, flags, ovf_sticky, retired_cnt all 0.
//   in_ready=0 and out_valid=0 while rst is high.
//  FSM states IDLE, EXEC, STALL:
//   IDLE: in_ready=1. On accept, latch op into alu_* regs and rd/flag_we side regs -> EXEC.
//   EXEC: ALU settles this cycle. push_ok = !full || (out_valid&&out_ready).
//    push_ok: push {alu_result,rd,alu_zero,alu_cout,alu_overflow}; in_ready=1;
//     if in_valid, latch next op and stay in EXEC (back-to-back, 1 op/cycle); else -> IDLE.
//    !push_ok: in_ready=0 -> STALL; alu_* regs hold.
//   STALL: in_ready=0; alu_* regs hold; push when push_ok, then -> IDLE (no accept this cycle).
//  Latency: accept at edge N -> ALU driven in cycle N+1 -> pushed at edge N+1 -> out_valid in N+2 if FIFO was empty.
//  FIFO: head is combinational from storage; push and pop on the same edge when full are both allowed, count unchanged.
//   Pop while empty is ignored. Pointers wrap modulo DEPTH.
//  Flags: on push with latched flag_we=1, flags <= {alu_zero,alu_cout,alu_overflow}; otherwise hold.
//   ovf_sticky |= alu_overflow on every push, regardless of flag_we.
//  retired_cnt increments by 1 per push; rolls from 2^CNT_W-1 to 0.
//  Reset asserted mid-operation discards in-flight op and FIFO contents; nothing is pushed on that edge.
//  in_op/in_bonus are passed unmodified; this block performs no arithmetic on operands.
// TESTING
//  1 Reset then in_op=4'b0010,src1=5,src2=7 single op, out_ready=1 -> out_valid in cycle N+2, out_result=12, out_flags=3'b000.
//  2 SUB 3-3 with flag_we=1 -> out_flags=3'b110 (zero, cout=1); flags=3'b110 after push; retired_cnt=1.
//  3 ADD 0x7FFFFFFF+1 flag_we=0 -> out_result=0x80000000, out_flags V=1; flags unchanged; ovf_sticky=1.
//  4 4 back-to-back ops, out_ready=0 -> 2 pushed, FSM enters STALL, in_ready=0; raise out_ready -> all 4 retire in order.
//  5 FIFO full, push and pop on same edge -> count stays DEPTH, order preserved, no lost/duplicate entry.
//  6 Assert rst for 1 cycle while in EXEC with FIFO non-empty -> next cycle out_valid=0, flags=0, retired_cnt=0, state IDLE.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | alu_issue_ctrl : ALU issue/retire controller with result FIFO and flags |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module alu_issue_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [2:0]       in_bonus,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic [4:0]       in_rd,
  input  logic             in_flag_we,
  output logic [WIDTH-1:0] alu_src1,
  output logic [WIDTH-1:0] alu_src2,
  output logic [3:0]       alu_ctrl,
  output logic [2:0]       alu_bonus,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_cout,
  input  logic             alu_overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_flags,
  output logic [2:0]       flags,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_depth = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_STALL = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [WIDTH-1:0] r_alu_src1, r_alu_src2;
  logic [3:0]       r_alu_ctrl;
  logic [2:0]       r_alu_bonus;
  logic [4:0]       r_rd;
  logic             r_flag_we;

  logic [WIDTH-1:0] r_res_mem [DEPTH];
  logic [4:0]       r_rd_mem  [DEPTH];
  logic [2:0]       r_flg_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [PTR_W:0]   r_count;

  logic [2:0]       r_flags;
  logic             r_ovf_sticky;
  logic [CNT_W-1:0] r_retired;

  logic w_full, w_pop, w_push_ok, w_push, w_in_ready, w_accept;

  assign w_full    = (r_count == c_depth);
  assign out_valid = !rst && (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  // A pop on the same edge frees the slot the push needs.
  assign w_push_ok = !w_full || w_pop;
  assign w_accept  = in_valid && w_in_ready;

  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_push     = 1'b0;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          w_in_ready = 1'b1;
          if (in_valid) w_next = S_EXEC;
        end
        S_EXEC: begin
          if (w_push_ok) begin
            w_push     = 1'b1;
            w_in_ready = 1'b1;
            w_next     = in_valid ? S_EXEC : S_IDLE;
          end else begin
            w_next = S_STALL;
          end
        end
        S_STALL: begin
          if (w_push_ok) begin
            w_push = 1'b1;
            w_next = S_IDLE;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_alu_src1   <= '0;
      r_alu_src2   <= '0;
      r_alu_ctrl   <= '0;
      r_alu_bonus  <= '0;
      r_rd         <= '0;
      r_flag_we    <= 1'b0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_flags      <= '0;
      r_ovf_sticky <= 1'b0;
      r_retired    <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_alu_src1  <= in_src1;
        r_alu_src2  <= in_src2;
        r_alu_ctrl  <= in_op;
        r_alu_bonus <= in_bonus;
        r_rd        <= in_rd;
        r_flag_we   <= in_flag_we;
      end
      if (w_push) begin
        r_wptr       <= r_wptr + 1'b1;
        r_retired    <= r_retired + 1'b1;
        r_ovf_sticky <= r_ovf_sticky | alu_overflow;
        if (r_flag_we) r_flags <= {alu_zero, alu_cout, alu_overflow};
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_res_mem[r_wptr] <= alu_result;
      r_rd_mem[r_wptr]  <= r_rd;
      r_flg_mem[r_wptr] <= {alu_zero, alu_cout, alu_overflow};
    end
  end

  assign in_ready    = w_in_ready;
  assign alu_src1    = r_alu_src1;
  assign alu_src2    = r_alu_src2;
  assign alu_ctrl    = r_alu_ctrl;
  assign alu_bonus   = r_alu_bonus;
  assign out_result  = r_res_mem[r_rptr];
  assign out_rd      = r_rd_mem[r_rptr];
  assign out_flags   = r_flg_mem[r_rptr];
  assign flags       = r_flags;
  assign ovf_sticky  = r_ovf_sticky;
  assign retired_cnt = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_alu_issue_ctrl : directed bench with a behavioural ALU in the loop    |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module tb_alu_issue_ctrl;

  localparam logic [3:0] c_add = 4'b0010;
  localparam logic [3:0] c_sub = 4'b0110;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [2:0]  in_bonus = '0;
  logic [31:0] in_src1 = '0;
  logic [31:0] in_src2 = '0;
  logic [4:0]  in_rd = '0;
  logic        in_flag_we = 1'b0;
  logic [31:0] alu_src1, alu_src2;
  logic [3:0]  alu_ctrl;
  logic [2:0]  alu_bonus;
  logic [31:0] alu_result;
  logic        alu_zero, alu_cout, alu_overflow;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic [2:0]  out_flags;
  logic [2:0]  flags;
  logic        ovf_sticky;
  logic [15:0] retired_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_bonus(in_bonus),
    .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd), .in_flag_we(in_flag_we),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_ctrl(alu_ctrl), .alu_bonus(alu_bonus),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout),
    .alu_overflow(alu_overflow),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_flags(out_flags),
    .flags(flags), .ovf_sticky(ovf_sticky), .retired_cnt(retired_cnt)
  );

  // Behavioural ALU: {A_inv, B_inv, op}; carry-in follows B_inv so 0110 subtracts.
  logic [31:0] m_a, m_b;
  logic [32:0] m_sum;
  always_comb begin
    m_a          = alu_ctrl[3] ? ~alu_src1 : alu_src1;
    m_b          = alu_ctrl[2] ? ~alu_src2 : alu_src2;
    m_sum        = {1'b0, m_a} + {1'b0, m_b} + {32'b0, alu_ctrl[2]};
    alu_cout     = 1'b0;
    alu_overflow = 1'b0;
    case (alu_ctrl[1:0])
      2'b00:   alu_result = m_a & m_b;
      2'b01:   alu_result = m_a | m_b;
      2'b10: begin
        alu_result   = m_sum[31:0];
        alu_cout     = m_sum[32];
        alu_overflow = (m_a[31] == m_b[31]) && (m_sum[31] != m_a[31]);
      end
      default: alu_result = {31'b0, m_sum[31]};
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic drive_op(input logic [3:0] op, input logic [31:0] s1,
                          input logic [31:0] s2, input logic [4:0] rd, input logic fwe);
    in_valid   = 1'b1;
    in_op      = op;
    in_src1    = s1;
    in_src2    = s2;
    in_rd      = rd;
    in_flag_we = fwe;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    @(posedge clk); #1;
    n_cmp++; if (flags !== 3'b000) begin n_fail++; $display("FAIL rst_flags got %b want 000", flags); end
    n_cmp++; if (retired_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got %0d want 0", retired_cnt); end
    n_cmp++; if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL rst_sticky got %b want 0", ovf_sticky); end
    n_cmp++; if ({alu_src1, alu_ctrl} !== 36'd0) begin n_fail++; $display("FAIL rst_alu_drive got %h/%h want 0", alu_src1, alu_ctrl); end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_add();
    do_reset();
    drive_op(c_add, 32'd5, 32'd7, 5'd3, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (alu_src1 !== 32'd5 || alu_src2 !== 32'd7 || alu_ctrl !== c_add) begin
      n_fail++; $display("FAIL add_drive got %h %h %b want 5 7 0010", alu_src1, alu_src2, alu_ctrl); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_early_valid got %b want 0", out_valid); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL add_valid got %b want 1", out_valid); end
    n_cmp++; if (out_result !== 32'd12) begin n_fail++; $display("FAIL add_result got %h want 0000000c", out_result); end
    n_cmp++; if (out_flags !== 3'b000) begin n_fail++; $display("FAIL add_flags got %b want 000", out_flags); end
    n_cmp++; if (out_rd !== 5'd3) begin n_fail++; $display("FAIL add_rd got %0d want 3", out_rd); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL add_popped got %b want 0", out_valid); end
  endtask

  task automatic test_sub_then_overflow();
    do_reset();
    out_ready = 1'b1;
    drive_op(c_sub, 32'd3, 32'd3, 5'd1, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_result !== 32'd0) begin n_fail++; $display("FAIL sub_result got %h want 0", out_result); end
    n_cmp++; if (out_flags !== 3'b110) begin n_fail++; $display("FAIL sub_outflags got %b want 110", out_flags); end
    n_cmp++; if (flags !== 3'b110) begin n_fail++; $display("FAIL sub_flags got %b want 110", flags); end
    n_cmp++; if (retired_cnt !== 16'd1) begin n_fail++; $display("FAIL sub_cnt got %0d want 1", retired_cnt); end
    @(posedge clk); #1;
    drive_op(c_add, 32'h7FFF_FFFF, 32'd1, 5'd2, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_result !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_result got %h want 80000000", out_result); end
    n_cmp++; if (out_flags !== 3'b001) begin n_fail++; $display("FAIL ovf_outflags got %b want 001", out_flags); end
    n_cmp++; if (flags !== 3'b110) begin n_fail++; $display("FAIL ovf_flags_hold got %b want 110", flags); end
    n_cmp++; if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", ovf_sticky); end
    n_cmp++; if (retired_cnt !== 16'd2) begin n_fail++; $display("FAIL ovf_cnt got %0d want 2", retired_cnt); end
    @(posedge clk); #1;
  endtask

  // Four ops against a blocked sink: two fill the FIFO, the controller stalls, then all drain.
  task automatic test_back_to_back();
    int sent, popped;
    logic acc;
    do_reset();
    sent = 0; popped = 0;
    for (int c = 0; c < 40 && popped < 4; c++) begin
      out_ready = (c >= 6);
      if (sent < 4) drive_op(c_add, 32'(100 + sent), 32'(sent), 5'(sent), 1'b0);
      else in_valid = 1'b0;
      #1;
      if (c == 5) begin
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_ready got %b want 0", in_ready); end
        n_cmp++; if (retired_cnt !== 16'd2) begin n_fail++; $display("FAIL b2b_stall_cnt got %0d want 2", retired_cnt); end
        n_cmp++; if (out_result !== 32'd100) begin n_fail++; $display("FAIL b2b_stall_head got %0d want 100", out_result); end
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        n_cmp++; if (out_result !== 32'(100 + 2 * popped) || out_rd !== 5'(popped)) begin
          n_fail++; $display("FAIL b2b_order[%0d] got %0d/rd%0d want %0d/rd%0d",
                              popped, out_result, out_rd, 100 + 2 * popped, popped); end
        popped++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
    end
    in_valid = 1'b0;
    n_cmp++; if (popped != 4) begin n_fail++; $display("FAIL b2b_drain_timeout got %0d want 4", popped); end
  endtask

  // Full FIFO with simultaneous push and pop every cycle: no bubble, order preserved.
  task automatic test_full_pushpop();
    int sent, popped;
    logic acc;
    do_reset();
    sent = 0; popped = 0;
    for (int c = 0; c < 40 && popped < 6; c++) begin
      out_ready = (c >= 3);
      if (sent < 6) drive_op(c_add, 32'(200 + sent), 32'd1, 5'(sent + 8), 1'b0);
      else in_valid = 1'b0;
      #1;
      if (c >= 3 && c <= 5) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL full_in_ready c%0d got %b want 1", c, in_ready); end
      end
      if (c >= 3 && c <= 6) begin
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL full_out_valid c%0d got %b want 1", c, out_valid); end
      end
      if (c == 6) begin
        n_cmp++; if (retired_cnt !== 16'd5) begin n_fail++; $display("FAIL full_cnt got %0d want 5", retired_cnt); end
      end
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        n_cmp++; if (out_result !== 32'(201 + popped) || out_rd !== 5'(popped + 8)) begin
          n_fail++; $display("FAIL full_order[%0d] got %0d/rd%0d want %0d/rd%0d",
                              popped, out_result, out_rd, 201 + popped, popped + 8); end
        popped++;
      end
      @(posedge clk); #1;
      if (acc) sent++;
    end
    in_valid = 1'b0;
    n_cmp++; if (popped != 6) begin n_fail++; $display("FAIL full_drain_timeout got %0d want 6", popped); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_no_dup got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_op(c_sub, 32'd3, 32'd3, 5'd4, 1'b1);
    @(posedge clk); #1;
    drive_op(c_add, 32'd1, 32'd1, 5'd5, 1'b1);
    @(posedge clk); #1;
    n_cmp++; if (flags !== 3'b110 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_setup got flags %b valid %b want 110 1", flags, out_valid); end
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
    n_cmp++; if (flags !== 3'b000) begin n_fail++; $display("FAIL mid_flags got %b want 000", flags); end
    n_cmp++; if (retired_cnt !== 16'd0) begin n_fail++; $display("FAIL mid_cnt got %0d want 0", retired_cnt); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_idle got %b want 1", in_ready); end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0 || retired_cnt !== 16'd0) begin
      n_fail++; $display("FAIL mid_no_push got valid %b cnt %0d want 0 0", out_valid, retired_cnt); end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_single_add();
    test_sub_then_overflow();
    test_back_to_back();
    test_full_pushpop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
